// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;

  // Rotate so the pointer position lands on bit 0.
  assign rot = N_REQ'({req, req} >> ptr);

  // Scan from the far end so the lowest rotated position wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte streams.
// Owns the tx_wr strobe and waits out each character on tx_busy.
// Optional message lock: define UART_TX_ARBITER_LOCK_EN to keep the
// transmitter with one requester until it sends a byte marked req_last.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int BUSY_TO = 8,
  localparam int IDX_W  = idx_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_wr,
  input  logic               tx_busy,
  output logic [IDX_W-1:0]   grant_id,
  output logic               locked,
  output logic               to_err
);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_SEND    = 2'(SEND);
  localparam logic [1:0] ST_WAIT_HI = 2'(WAIT_HI);
  localparam logic [1:0] ST_WAIT_LO = 2'(WAIT_LO);

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] ptr_upd;
  logic [7:0]       to_cnt;
  logic [7:0]       win_data;
  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] cand;
  logic             found;
  logic             accept;

  // While locked only the holder may compete.
  assign grant_oh = N_REQ'(1) << grant_id;
  assign cand     = locked ? (req_valid & grant_oh) : req_valid;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (win)
  );

  // Reset is folded in so req_ready reads 0 while reset is held.
  assign accept    = rst && (state == ST_IDLE) && found && !tx_busy;
  assign req_ready = accept ? (N_REQ'(1) << win) : '0;
  assign win_data  = 8'(req_data >> {win, 3'b000});
  assign nxt_ptr   = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign tx_wr     = (state == ST_SEND);

`ifdef UART_TX_ARBITER_LOCK_EN
  logic last_sel;

  assign last_sel = |(req_last & req_ready);
  // Pointer parks on the holder until the releasing byte goes out.
  assign ptr_upd  = last_sel ? nxt_ptr : win;

  // Lock is taken by any non-final byte and dropped by the final one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked <= 1'b0;
    end else if (accept) begin
      locked <= !last_sel;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign ptr_upd     = nxt_ptr;
  assign locked      = 1'b0;
`endif

  // Accept, strobe, then follow tx_busy high and low (or time out).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      to_cnt   <= 8'h00;
      to_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_data  <= win_data;
            grant_id <= win;
            rr_ptr   <= ptr_upd;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          to_cnt <= 8'h00;
          state  <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state <= ST_WAIT_LO;
          end else if (to_cnt == 8'(BUSY_TO - 1)) begin
            // Core never picked the byte up; treat it as sent.
            to_err <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 8'h01;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single transmitter of the UART core between `N_REQ` byte-stream requesters, e.g. the CPU-side UART peripheral and a hardware debug/log source.
- Sits between the requesters and the core's `tx_data`/`tx_wr`/`tx_busy` handshake.
- Grants round-robin, owns `tx_wr` sequencing, and optionally locks the transmitter to one requester until it marks the last byte of a message.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, 2..8.
- `BUSY_TO`, 8: cycles to wait for `tx_busy` to rise after `tx_wr` before giving up on that byte, 2..255.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  N_REQ  requester i has a byte.
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- `req_last`  in  N_REQ  byte is the last of a message.
- `req_ready`  out  N_REQ  one-hot; byte of requester i accepted this cycle.
- `tx_data`  out  8  byte to the UART core.
- `tx_wr`  out  1  one-cycle write strobe to the UART core.
- `tx_busy`  in  1  UART core transmitting.
- `grant_id`  out  $clog2(N_REQ)  index of the last accepted requester.
- `locked`  out  1  transmitter reserved for `grant_id`.
- `to_err`  out  1  sticky flag: a `BUSY_TO` timeout occurred. Cleared only by reset.

## Operation
States: IDLE, SEND, WAIT_HI, WAIT_LO.

IDLE
- Candidate set:
  - if `locked`, only `grant_id`;
  - otherwise all i with `req_valid[i]`.
- Winner: first candidate at or after pointer `rr_ptr`, wrapping modulo `N_REQ`.
- Accept when any candidate exists and `tx_busy`=0:
  - `req_ready[winner]`=1 combinationally in that cycle;
  - on the edge, capture `req_data` into `tx_data` and set `grant_id`=winner;
  - `rr_ptr`=(winner+1) mod N_REQ, or held at winner if the lock is taken;
  - go to SEND.
- `tx_busy`=1 in IDLE (foreign or previous activity): no accept.

SEND
- `tx_wr`=1 for exactly this cycle. Clear the timeout counter and go to WAIT_HI.

WAIT_HI
- `tx_busy`=1: go to WAIT_LO.
- Counter reaches `BUSY_TO`: set `to_err`, go to IDLE; the byte counts as sent.

WAIT_LO
- `tx_busy`=0: go to IDLE.

Rules
- `req_ready` is never asserted outside IDLE.
- The handshake is valid&ready. A requester may drop `req_valid` at any time without penalty.
- `tx_data` is stable from SEND until the next accept.

## Timing
- Reset values: `req_ready`=0, `tx_data`=0, `tx_wr`=0, `grant_id`=0, `locked`=0, `to_err`=0. Internal: `rr_ptr`=0, state IDLE.
- Reset mid-byte aborts the sequence. The UART core may finish the current character on its own; the arbiter waits on `tx_busy`=0 before the next accept.
- Latency: accept at edge k, `tx_wr` high during cycle k+1, WAIT_HI from k+2.
- Minimum spacing between accepts is 4 cycles plus the UART character time.
- Simultaneous `req_valid`: exactly one `req_ready`, chosen by pointer order.
- Pointer wrap: after a grant to N_REQ-1, `rr_ptr`=0.

## Configuration
- `UART_TX_ARBITER_LOCK_EN` defined:
  - accepting a byte with `req_last`=0 sets `locked`;
  - accepting a byte with `req_last`=1 clears it;
  - while locked, other requesters are starved even if the holder drops `req_valid`;
  - `rr_ptr` advances only on the releasing byte.
- Not defined:
  - `locked` is tied to 0 and `req_last` is ignored;
  - arbitration is per byte;
  - `rr_ptr` advances on every accept.

## Structure
- Package `uart_arb_pkg`:
  - state enumeration (IDLE, SEND, WAIT_HI, WAIT_LO);
  - function computing the index width from `N_REQ` (minimum 1).
- Sub-module `rr_picker`: combinational, given request vector and pointer, returns found flag and winner index.
- FSM, counters, pointer and lock stay in `uart_tx_arbiter`.

## Test plan
- Single requester: `req_valid[0]`, data 0x41; core model raises busy 2 cycles after `tx_wr` and holds it 10 cycles. Expect `tx_wr` one cycle after `req_ready[0]`, `tx_data`=0x41, next accept no earlier than the cycle after busy falls.
- Fairness, N_REQ=2, both valid continuously with 0xA0/0xB0: accepted order 0,1,0,1; `grant_id` alternates.
- Lock (macro defined): req0 sends 0x10,0x11,0x12 with `req_last` only on 0x12 while req1 is valid. Expect req1 granted only after 0x12. Expect `locked` high from accepting 0x10 until accepting 0x12.
- Lock compiled out, same stimulus: bytes interleave 0x10, req1, 0x11, req1, …; `locked` stays 0.
- Timeout, BUSY_TO=8: core never raises busy. Expect `to_err`=1 eight cycles into WAIT_HI, return to IDLE, next byte accepted.
- Reset mid-WAIT_LO: assert `rst`=0 for 1 cycle. Expect all outputs at reset values immediately. With busy still high, no accept until busy falls.
